// File: rtl/fetch_unit_param.sv
// Multi-bank instruction fetch unit: per-program instruction banks, a PC with
// absolute/relative branching, halt detection and PC range fault detection.
module fetch_unit_param #(
    parameter int                INST_W    = 9,
    parameter int                PC_W      = 8,
    parameter int                NUM_PROGS = 3,
    parameter int                PS_W      = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1,
    parameter logic [INST_W-1:0] HALT_WORD = '1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [PS_W-1:0]   prog_sel,
    input  logic [PC_W-1:0]   start_addr,
    input  logic              advance,
    input  logic              branch,
    input  logic [PC_W-1:0]   target,
    input  logic              branchi,
    input  logic              jump,
    input  logic [5:0]        immediate,
    input  logic              wr_en,
    input  logic [PS_W-1:0]   wr_prog,
    input  logic [PC_W-1:0]   wr_addr,
    input  logic [INST_W-1:0] wr_data,
    output logic [INST_W-1:0] inst,
    output logic              inst_valid,
    output logic [PC_W-1:0]   pc,
    output logic              done,
    output logic              fault,
    output logic [1:0]        state
);

    localparam int DEPTH = 1 << PC_W;
    localparam logic [PS_W:0] NP = NUM_PROGS[PS_W:0];

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

    logic [INST_W-1:0] mem [NUM_PROGS][DEPTH];

    logic [1:0]      nxt_state;
    logic [PC_W-1:0] nxt_pc;
    logic [PS_W-1:0] bank;
    logic [PS_W-1:0] nxt_bank;
    logic            fetch;
    logic            start_ok;
    logic            wr_ok;

    logic [4:0]      step_mag;
    logic            step_neg;
    logic [PC_W:0]   pc_ext;
    logic [PC_W:0]   mag_ext;
    logic [PC_W:0]   rel_sum;
    logic            rel_over;

    assign start_ok = ({1'b0, prog_sel} < NP);
    assign wr_ok    = ({1'b0, wr_prog} < NP);

    // Offset selection: long form uses a 5-bit magnitude with sign in bit 5,
    // short form a 3-bit magnitude with sign in bit 3; plain advance is +1.
    always_comb begin
        step_mag = 5'd1;
        step_neg = 1'b0;
        if (branchi && jump) begin
            step_mag = immediate[4:0];
            step_neg = immediate[5];
        end else if (branchi) begin
            step_mag = {2'b00, immediate[2:0]};
            step_neg = immediate[3];
        end
    end

    // One extra bit of headroom exposes both overflow and underflow; no wrap.
    assign pc_ext   = {1'b0, pc};
    assign mag_ext  = (PC_W + 1)'(step_mag);
    assign rel_sum  = step_neg ? (pc_ext - mag_ext) : (pc_ext + mag_ext);
    assign rel_over = step_neg ? (mag_ext > pc_ext) : rel_sum[PC_W];

    always_comb begin
        nxt_state = state;
        nxt_pc    = pc;
        nxt_bank  = bank;
        fetch     = 1'b0;
        if (start) begin
            if (start_ok) begin
                nxt_state = ST_RUN;
                nxt_bank  = prog_sel;
                nxt_pc    = start_addr;
                fetch     = 1'b1;
            end else begin
                nxt_state = ST_FAULT;
            end
        end else if (state == ST_RUN && advance) begin
            if (inst == HALT_WORD) begin
                nxt_state = ST_DONE;
            end else if (branch) begin
                nxt_pc = target;
                fetch  = 1'b1;
            end else if (rel_over) begin
                nxt_state = ST_FAULT;
            end else begin
                nxt_pc = rel_sum[PC_W-1:0];
                fetch  = 1'b1;
            end
        end
    end

    // Bank loads are only allowed while no program is running.
    always_ff @(posedge clk) begin
        if (wr_en && state != ST_RUN && wr_ok) begin
            mem[wr_prog][wr_addr] <= wr_data;
        end
    end

    // The read is addressed by next-PC so inst and pc move together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            pc    <= '0;
            bank  <= '0;
            inst  <= '0;
        end else begin
            state <= nxt_state;
            pc    <= nxt_pc;
            bank  <= nxt_bank;
            if (fetch) begin
                inst <= mem[nxt_bank][nxt_pc];
            end
        end
    end

    assign inst_valid = (state == ST_RUN);
    assign done       = (state == ST_DONE);
    assign fault      = (state == ST_FAULT);

endmodule
